// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU with a start/busy/done handshake.
// Shifts run one bit per cycle and MUL is an unsigned shift-add over WIDTH cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete straight to FIN
// EXEC  | iterative shift or multiply step; count runs down to 1
// FIN   | result/flags valid, done pulses; a new start is accepted here
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             s_flag,
    output logic             v_flag,
    output logic             illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [SHW:0]     count;
    logic [WIDTH-1:0] work_a;   // shift value, or MUL upper product half
    logic [WIDTH-1:0] work_b;   // MUL lower product half / remaining multiplier bits
    logic [WIDTH-1:0] mcand;

    logic             accept;
    logic             is_shift;
    logic             multi;
    logic             last_step;
    logic             fin_load;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_v;
    logic             fin_ill;

    assign busy      = (state == EXEC);
    assign accept    = start && !busy;
    assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign multi     = (is_shift && (y[SHW-1:0] != '0)) || (op == OP_MUL);
    assign last_step = (state == EXEC) && (count == CNT_ONE);
    assign fin_load  = last_step || (accept && !multi);

    // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
    always_comb begin
        add_b   = (op == OP_SUB) ? ~y : y;
        add_sum = {1'b0, x} + {1'b0, add_b} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (x[WIDTH-1] == add_b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: alu_res = x & y;
            OP_OR:  alu_res = x | y;
            OP_XOR: alu_res = x ^ y;
            OP_NOR: alu_res = ~(x | y);
            OP_SLL, OP_SRL, OP_SRA: alu_res = x;   // only reached with amount 0
            OP_MUL: alu_res = '0;                  // always iterative
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        sh_next = work_a;
        sh_out  = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_next = {work_a[WIDTH-2:0], 1'b0};
                sh_out  = work_a[WIDTH-1];
            end
            OP_SRL: begin
                sh_next = {1'b0, work_a[WIDTH-1:1]};
                sh_out  = work_a[0];
            end
            OP_SRA: begin
                sh_next = {work_a[WIDTH-1], work_a[WIDTH-1:1]};
                sh_out  = work_a[0];
            end
            default: begin
                sh_next = work_a;
                sh_out  = 1'b0;
            end
        endcase
    end

    // Shift-add step: conditionally add multiplicand to the upper half, then
    // shift the whole 2*WIDTH product right by one.
    always_comb begin
        mul_sum     = {1'b0, work_a} + (work_b[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_b[WIDTH-1:1]};
    end

    always_comb begin
        fin_res = alu_res;
        fin_c   = alu_c;
        fin_v   = alu_v;
        fin_ill = alu_ill;
        if (state == EXEC) begin
            fin_ill = 1'b0;
            if (op_q == OP_MUL) begin
                fin_res = mul_lo_next;
                fin_c   = (mul_hi_next != '0);
                fin_v   = (mul_hi_next != '0);
            end else begin
                fin_res = sh_next;
                fin_c   = sh_out;
                fin_v   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            count   <= '0;
            work_a  <= '0;
            work_b  <= '0;
            mcand   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            result  <= '0;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            s_flag  <= 1'b0;
            v_flag  <= 1'b0;
        end else begin
            done    <= fin_load;
            illegal <= fin_load && fin_ill;
            if (fin_load) begin
                result <= fin_res;
                c_flag <= fin_c;
                v_flag <= fin_v;
                z_flag <= (fin_res == '0);
                s_flag <= fin_res[WIDTH-1];
            end
            case (state)
                IDLE, FIN: begin
                    if (accept && multi) begin
                        state  <= EXEC;
                        op_q   <= op;
                        work_b <= y;
                        mcand  <= x;
                        if (op == OP_MUL) begin
                            count  <= CNT_MUL;
                            work_a <= '0;
                        end else begin
                            count  <= {1'b0, y[SHW-1:0]};
                            work_a <= x;
                        end
                    end else if (accept) begin
                        state <= FIN;
                        op_q  <= op;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    count <= count - CNT_ONE;
                    if (op_q == OP_MUL) begin
                        work_a <= mul_hi_next;
                        work_b <= mul_lo_next;
                    end else begin
                        work_a <= sh_next;
                    end
                    if (last_step) begin
                        state <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor of the datapath ALU.
- Generalised operand width; full C/Z/S/V flag set; iterative shifts and iterative multiply.
- start/busy/done handshake, so the control FSM can issue an op and stall until completion.
- Sits in the execute stage between the register-file read ports and the writeback mux.

Parameters:
- WIDTH, 32, operand and result width in bits; minimum 4, power of two.
- SHW, $clog2(WIDTH), number of bits of the shift-amount field taken from y.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue request; sampled only while busy=0.
- op  in  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10-15 illegal.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B; y[SHW-1:0] is the shift amount for ops 6-8.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result.
- c_flag  out  1  carry.
- z_flag  out  1  zero.
- s_flag  out  1  sign.
- v_flag  out  1  overflow.
- illegal  out  1  set with done when op was 10-15.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, result, all flags and illegal = 0. Applies mid-operation; any in-flight op is discarded and produces no done.
- FSM states: IDLE, EXEC, FIN.
  - IDLE: on start=1, latch op, x, y and count.
    - Single-cycle ops (0-5, illegal, shifts with amount 0): go to FIN.
    - Shifts with amount > 0 and MUL: go to EXEC.
  - EXEC: one step per cycle; count decrements; at count=1 go to FIN.
    - Shifts: count = shift amount.
    - MUL: count = WIDTH.
  - FIN: result and flags register; done=1 for exactly this cycle; go to IDLE.
- busy:
  - 1 in EXEC, and in FIN only if a new start is not acceptable.
  - Rule: busy=0 in FIN; a start in the FIN cycle is accepted (back-to-back issue allowed).
- start while busy=1 is ignored; inputs x, y and op may change freely after the accept cycle.
- Latency, counted from the accept edge to the done cycle:
  - Ops 0-5, illegal, shift amount 0: 1.
  - Shifts: amount+1.
  - MUL: WIDTH+1.
- result and flags hold their last values until the next FIN; they do not change in IDLE or EXEC.
- ADD and SUB:
  - ADD: WIDTH-bit add; c_flag = carry out.
  - SUB: x + ~y + 1; c_flag = carry out (1 means no borrow).
  - v_flag = signed overflow (operand signs equal, result sign differs; for SUB, evaluated on x and ~y).
- Logic ops 2-5: c_flag = 0, v_flag = 0.
- Shifts:
  - One bit position per EXEC cycle.
  - SRA replicates the MSB.
  - c_flag = last bit shifted out (0 if amount = 0).
  - v_flag = 0.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle, 2*WIDTH-bit internal product.
  - result = low WIDTH bits.
  - c_flag = v_flag = (upper WIDTH bits != 0).
- Illegal op: result = 0, flags computed from result 0 (z_flag = 1), illegal = 1 for the done cycle only. illegal is 0 on every legal completion.
- z_flag = (result == 0) and s_flag = result[WIDTH-1], for all ops.

Test Plan:
- Reset: assert rst mid-MUL (cycle 5 of 33) → busy, done, result and flags = 0 immediately; no done pulse follows; next ADD completes normally.
- ADD (WIDTH=32): x=0x7FFFFFFF, y=1 → done 1 cycle after accept, result=0x80000000, V=1, S=1, C=0, Z=0.
- SUB: x=5, y=5 → result=0, Z=1, C=1, V=0.
- SUB: x=0, y=1 → result=0xFFFFFFFF, C=0, S=1.
- Shifts:
  - SRA, x=0x80000001, y=4 → done at cycle 5, busy high for cycles 1-4, result=0xF8000000, C=0.
  - SLL with y=0 → done at cycle 1, result=x, C=0.
- MUL: x=0x10000, y=0x10000 → done at cycle 33, result=0, Z=1, C=V=1. Then x=7, y=6 → result=42, C=V=0.
- Handshake:
  - start held high through an op → no second issue until FIN.
  - start in the FIN cycle with op=AND, x=0xF0, y=0x3C → second done exactly 1 cycle later, result=0x30.
  - op=12 → done after 1 cycle, illegal=1, result=0, Z=1.
